// File: rtl/uart_rx_deserializer.sv
// Receive half of a 16550-style UART: oversampled start detect, 5-8 data bits,
// optional parity, one checked stop bit, and per-frame PE/FE/BI/OE reporting.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       stick_parity_i,
  input  logic       rx_fifo_full_i,
  output logic       rx_push_o,
  output logic [7:0] rx_data_o,
  output logic       rx_pe_o,
  output logic       rx_fe_o,
  output logic       rx_bi_o,
  output logic       rx_oe_o,
  output logic       rx_busy_o
);
  localparam int TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             data;
  logic [1:0]             wls;
  logic                   pen, eps, stick, par_bit;
  logic                   rx_s, mid_start, mid_bit, last_bit, exp_par;

  assign rx_s      = sync[SYNC_STAGES-1];
  assign mid_start = baud_pulse && (tick_cnt == TW'(OVERSAMPLE/2 - 1));
  assign mid_bit   = baud_pulse && (tick_cnt == TW'(OVERSAMPLE - 1));
  // bit_cnt of the final data bit is 4+wls, i.e. {1,wls}
  assign last_bit  = (bit_cnt == {1'b1, wls});
  // unreceived upper bits of data are held at 0, so the reduction covers the word only
  assign exp_par   = stick ? ~eps : (eps ? ^data : ~^data);
  assign rx_busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (!rx_s) state_nx = START;
      START:    if (mid_start) state_nx = rx_s ? IDLE : DATA;
      DATA:     if (mid_bit && last_bit) state_nx = pen ? PARITY : STOP;
      PARITY:   if (mid_bit) state_nx = STOP;
      STOP:     if (mid_bit) state_nx = rx_s ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_s) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      wls       <= '0;
      pen       <= 1'b0;
      eps       <= 1'b0;
      stick     <= 1'b0;
      par_bit   <= 1'b0;
      rx_push_o <= 1'b0;
      rx_data_o <= '0;
      rx_pe_o   <= 1'b0;
      rx_fe_o   <= 1'b0;
      rx_bi_o   <= 1'b0;
      rx_oe_o   <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], rx_i};
      rx_push_o <= 1'b0;
      if (baud_pulse) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          data     <= '0;
          par_bit  <= 1'b0;
          wls      <= wls_i;
          pen      <= pen_i;
          eps      <= eps_i;
          stick    <= stick_parity_i;
        end
        START: if (mid_start) tick_cnt <= '0;
        DATA: if (mid_bit) begin
          tick_cnt      <= '0;
          data[bit_cnt] <= rx_s;
          bit_cnt       <= bit_cnt + 1'b1;
        end
        PARITY: if (mid_bit) begin
          tick_cnt <= '0;
          par_bit  <= rx_s;
        end
        STOP: if (mid_bit) begin
          tick_cnt  <= '0;
          rx_data_o <= data;
          rx_pe_o   <= pen && (par_bit != exp_par);
          rx_fe_o   <= ~rx_s;
          rx_bi_o   <= (data == 8'h00) && !(pen && par_bit) && !rx_s;
          rx_push_o <= ~rx_fifo_full_i;
          rx_oe_o   <= rx_fifo_full_i;
        end
        default: tick_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized frame bench for uart_rx_deserializer; expected flags come from a
// frame-level model of the serial format.
module tb_uart_rx_deserializer;
  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic       clk = 0, rst = 1, baud_pulse = 0, rx = 1;
  logic [1:0] wls = 2'b11;
  logic       pen = 0, eps = 0, stick = 0, full = 0;
  logic       push, pe, fe, bi, oe, busy;
  logic [7:0] rdata;

  int n_chk = 0, n_pass = 0, pushes = 0, dbl = 0, dcnt = 0;
  logic prev_push = 0;

  uart_rx_deserializer #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx_i(rx), .wls_i(wls),
    .pen_i(pen), .eps_i(eps), .stick_parity_i(stick), .rx_fifo_full_i(full),
    .rx_push_o(push), .rx_data_o(rdata), .rx_pe_o(pe), .rx_fe_o(fe),
    .rx_bi_o(bi), .rx_oe_o(oe), .rx_busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dcnt == DIV - 1) begin dcnt <= 0; baud_pulse <= 1'b1; end
    else begin dcnt <= dcnt + 1; baud_pulse <= 1'b0; end
  end

  always @(negedge clk) begin
    prev_push <= push;
    if (push) pushes <= pushes + 1;
    if (push && prev_push) dbl <= dbl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // Drive one frame; line configuration is scrambled after the start bit to
  // show that the receiver works from its own latched copy.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic p_en,
                            input logic par, input logic stop);
    rx = 0; bits(1);
    wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); stick = 1'($urandom);
    for (int i = 0; i < nb; i++) begin rx = d[i]; bits(1); end
    if (p_en) begin rx = par; bits(1); end
    rx = stop; bits(1);
    rx = 1; bits(1);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input int nb,
                       input logic p_en, input logic p_eps, input logic p_stick,
                       input logic corrupt, input logic stop, input logic f);
    logic [7:0] dm;
    int ones, p0;
    logic ep, par, e_bi;
    dm   = 8'((32'd1 << nb) - 1) & d;
    ones = $countones(dm);
    if (p_stick)    ep = !p_eps;
    else if (p_eps) ep = (ones % 2) == 1;
    else            ep = (ones % 2) == 0;
    par  = ep ^ corrupt;
    e_bi = (dm == 0) && !(p_en && par) && !stop;
    wls = 2'(nb - 5); pen = p_en; eps = p_eps; stick = p_stick; full = f;
    p0 = pushes;
    @(negedge clk);
    send_frame(dm, nb, p_en, par, stop);
    full = 0;
    chk({tag, "_push"}, pushes - p0, f ? 0 : 1);
    chk({tag, "_data"}, rdata, dm);
    chk({tag, "_pe"}, pe, p_en && corrupt);
    chk({tag, "_fe"}, fe, !stop);
    chk({tag, "_bi"}, bi, e_bi);
    chk({tag, "_oe"}, oe, f);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int p0;
    repeat (4) @(negedge clk);
    chk("rst_push", push, 0);
    chk("rst_data", rdata, 0);
    chk("rst_flags", {pe, fe, bi, oe}, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    bits(1);

    frame("8n1_a5", 8'hA5, 8, 0, 0, 0, 0, 1, 0);
    frame("7e1_bad", 8'h35, 7, 1, 1, 0, 1, 1, 0);
    frame("7e1_good", 8'h35, 7, 1, 1, 0, 0, 1, 0);
    frame("fe_0f", 8'h0F, 8, 0, 0, 0, 0, 0, 0);
    frame("ovr_55", 8'h55, 8, 0, 0, 0, 0, 1, 1);
    frame("after_ovr", 8'h3C, 8, 0, 0, 0, 0, 1, 0);
    frame("stick5", 8'h1F, 5, 1, 1, 1, 0, 1, 0);

    // break: line low for three frame times
    wls = 2'b11; pen = 0; p0 = pushes;
    @(negedge clk);
    rx = 0; bits(30);
    chk("brk_push", pushes - p0, 1);
    chk("brk_data", rdata, 0);
    chk("brk_bi_fe", {bi, fe}, 2'b11);
    chk("brk_busy", busy, 1);
    rx = 1; bits(2);
    chk("brk_end_busy", busy, 0);
    chk("brk_end_push", pushes - p0, 1);

    // glitch shorter than half a bit
    p0 = pushes;
    rx = 0; repeat (3 * DIV) @(negedge clk);
    rx = 1; bits(1);
    chk("glitch_push", pushes - p0, 0);
    chk("glitch_busy", busy, 0);

    // reset in the middle of the data bits
    p0 = pushes;
    rx = 0; bits(1);
    rx = 1; bits(1);
    rx = 0; repeat (BIT / 2) @(negedge clk);
    rst = 1; rx = 1;
    repeat (2) @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_outs", {push, rdata, pe, fe, bi, oe}, 0);
    rst = 0; bits(12);
    chk("mrst_push", pushes - p0, 0);
    chk("mrst_idle", busy, 0);

    for (int k = 0; k < 16; k++) begin
      frame($sformatf("rnd%0d", k), 8'($urandom), 5 + int'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    chk("push_width", dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
